fifo_wr_arbiter: RTL and testbench

- Round-robin arbiter that shares the single write port of the team's FIFO buffer between two producers.
- Each producer uses a valid/ready handshake. The arbiter grants one producer at a time for a burst of up to BURST_MAX words, then rotates.
- Sits directly in front of the FIFO: drives wr/w_data and observes the FIFO full flag for backpressure.

---
 rtl/fifo_wr_arbiter.sv | 139 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter sharing the single FIFO write port between two
//   valid/ready producers. A grant lasts up to BURST_MAX accepted words, or
//   until the owner drops valid, then rotates to the other producer if it is
//   waiting. A lone producer keeps the bus across burst boundaries with no
//   idle bubble.
//
// Ports
//   clk                     system clock, rising-edge
//   reset                   synchronous active-high reset
//   req0_valid/data/ready   producer 0 handshake
//   req1_valid/data/ready   producer 1 handshake
//   fifo_full               FIFO full flag (backpressure)
//   fifo_wr, fifo_wdata     FIFO write strobe and data
//   grant                   one-hot owner (bit0 = producer 0), 00 = idle
module fifo_wr_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BURST_MAX  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    input  logic                  fifo_full,
    output logic                  fifo_wr,
    output logic [DATA_WIDTH-1:0] fifo_wdata,
    output logic [1:0]            grant
);

    localparam int unsigned      CNT_W    = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_MAX - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t                state, state_next;
    logic [CNT_W-1:0]      cnt, cnt_next;
    logic                  last_owner, last_owner_next;
    logic [DATA_WIDTH-1:0] wdata_q;

    // Owner-relative view of the producers for the current grant state.
    logic                  own_valid;
    logic                  other_valid;
    logic [DATA_WIDTH-1:0] own_data;
    logic                  beat;
    logic                  release_bus;

    always_comb begin
        own_valid   = (state == GNT1) ? req1_valid : req0_valid;
        other_valid = (state == GNT1) ? req0_valid : req1_valid;
        own_data    = (state == GNT1) ? req1_data  : req0_data;
        beat        = (state != IDLE) && own_valid && !fifo_full;
        release_bus = (beat && (cnt == CNT_LAST)) || !own_valid;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            last_owner <= 1'b1;
            wdata_q    <= '0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            last_owner <= last_owner_next;
            wdata_q    <= fifo_wdata;
        end
    end

    // Next-state logic
    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        last_owner_next = last_owner;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (req0_valid && req1_valid)
                    state_next = last_owner ? GNT0 : GNT1;
                else if (req0_valid)
                    state_next = GNT0;
                else if (req1_valid)
                    state_next = GNT1;
            end
            GNT0, GNT1: begin
                if (release_bus) begin
                    last_owner_next = (state == GNT1);
                    cnt_next        = '0;
                    if (other_valid)
                        state_next = (state == GNT1) ? GNT0 : GNT1;
                    else if (own_valid)
                        state_next = state;
                    else
                        state_next = IDLE;
                end else if (beat) begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs; everything is forced quiet while reset is asserted so a
    // burst in flight performs no write in the reset cycle.
    always_comb begin
        grant      = 2'b00;
        fifo_wr    = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        fifo_wdata = wdata_q;
        if (reset) begin
            fifo_wdata = '0;
        end else begin
            case (state)
                GNT0: begin
                    grant      = 2'b01;
                    req0_ready = beat;
                end
                GNT1: begin
                    grant      = 2'b10;
                    req1_ready = beat;
                end
                default: ;
            endcase
            fifo_wr = beat;
            if (beat)
                fifo_wdata = own_data;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req1_valid;
    logic [7:0] req0_data, req1_data;
    logic       req0_ready, req1_ready;
    logic       fifo_full;
    logic       fifo_wr;
    logic [7:0] fifo_wdata;
    logic [1:0] grant;

    int nchk = 0;
    int nerr = 0;

    fifo_wr_arbiter #(.DATA_WIDTH(8), .BURST_MAX(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .fifo_full  (fifo_full),
        .fifo_wr    (fifo_wr),
        .fifo_wdata (fifo_wdata),
        .grant      (grant)
    );

    always #5 clk = ~clk;

    // Leaves the bench at a falling edge, first cycle after reset (IDLE).
    task automatic do_reset();
        reset      = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_data  = 8'h00;
        req1_data  = 8'h00;
        fifo_full  = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [12:0] obs, exp;
        reset      = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_data  = 8'h5A;
        req1_data  = 8'hA5;
        fifo_full  = 1'b0;
        for (int c = 0; c < 4; c++) begin
            reset = (c < 2);
            #1;
            obs = {grant, fifo_wr, req0_ready, req1_ready, fifo_wdata};
            exp = (c == 3) ? {2'b01, 1'b1, 1'b1, 1'b0, 8'h5A} : 13'h0;
            nchk++;
            if (obs !== exp) begin
                nerr++;
                $display("FAIL reset c=%0d got g=%b wr=%b r0=%b r1=%b d=%h exp g=%b wr=%b r0=%b r1=%b d=%h",
                         c, obs[12:11], obs[10], obs[9], obs[8], obs[7:0],
                         exp[12:11], exp[10], exp[9], exp[8], exp[7:0]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stream0();
        logic [12:0] obs, exp;
        logic [1:0]  eg;
        logic        ew;
        logic [7:0]  ed;
        int unsigned idx;
        do_reset();
        idx = 0;
        for (int c = 0; c <= 12; c++) begin
            req0_valid = (idx < 10);
            req0_data  = 8'h10 + 8'(idx);
            #1;
            ew = (c >= 1 && c <= 10);
            eg = (c >= 1 && c <= 11) ? 2'b01 : 2'b00;
            ed = (c == 0) ? 8'h00 : (c <= 10 ? 8'h10 + 8'(c - 1) : 8'h19);
            exp = {eg, ew, ew, 1'b0, ed};
            obs = {grant, fifo_wr, req0_ready, req1_ready, fifo_wdata};
            nchk++;
            if (obs !== exp) begin
                nerr++;
                $display("FAIL stream0 c=%0d got g=%b wr=%b r0=%b r1=%b d=%h exp g=%b wr=%b r0=%b r1=%b d=%h",
                         c, obs[12:11], obs[10], obs[9], obs[8], obs[7:0],
                         exp[12:11], exp[10], exp[9], exp[8], exp[7:0]);
            end
            if (req0_ready) idx++;
            @(negedge clk);
        end
    endtask

    task automatic test_alternate();
        logic [12:0] obs, exp;
        logic [1:0]  eg;
        logic        ew;
        logic [7:0]  ed;
        int unsigned i0, i1;
        do_reset();
        i0 = 0;
        i1 = 0;
        for (int c = 0; c <= 12; c++) begin
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            req0_data  = 8'hA0 + 8'(i0);
            req1_data  = 8'hB0 + 8'(i1);
            #1;
            if (c == 0) begin
                eg = 2'b00; ew = 1'b0; ed = 8'h00;
            end else if (c <= 4) begin
                eg = 2'b01; ew = 1'b1; ed = 8'hA0 + 8'(c - 1);
            end else if (c <= 8) begin
                eg = 2'b10; ew = 1'b1; ed = 8'hB0 + 8'(c - 5);
            end else begin
                eg = 2'b01; ew = 1'b1; ed = 8'hA4 + 8'(c - 9);
            end
            exp = {eg, ew, ew & eg[0], ew & eg[1], ed};
            obs = {grant, fifo_wr, req0_ready, req1_ready, fifo_wdata};
            nchk++;
            if (obs !== exp) begin
                nerr++;
                $display("FAIL alternate c=%0d got g=%b wr=%b r0=%b r1=%b d=%h exp g=%b wr=%b r0=%b r1=%b d=%h",
                         c, obs[12:11], obs[10], obs[9], obs[8], obs[7:0],
                         exp[12:11], exp[10], exp[9], exp[8], exp[7:0]);
            end
            if (req0_ready) i0++;
            if (req1_ready) i1++;
            @(negedge clk);
        end
    endtask

    task automatic test_full_stall();
        logic [12:0] obs, exp;
        logic [1:0]  eg;
        logic        ew;
        logic [7:0]  ed;
        int unsigned i0, i1;
        do_reset();
        i0 = 0;
        i1 = 0;
        for (int c = 0; c <= 8; c++) begin
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            req0_data  = 8'h30 + 8'(i0);
            req1_data  = 8'h40 + 8'(i1);
            fifo_full  = (c >= 3 && c <= 5);
            #1;
            case (c)
                0:       begin eg = 2'b00; ew = 1'b0; ed = 8'h00; end
                1, 2:    begin eg = 2'b01; ew = 1'b1; ed = 8'h30 + 8'(c - 1); end
                3, 4, 5: begin eg = 2'b01; ew = 1'b0; ed = 8'h31; end
                6, 7:    begin eg = 2'b01; ew = 1'b1; ed = 8'h32 + 8'(c - 6); end
                default: begin eg = 2'b10; ew = 1'b1; ed = 8'h40; end
            endcase
            exp = {eg, ew, ew & eg[0], ew & eg[1], ed};
            obs = {grant, fifo_wr, req0_ready, req1_ready, fifo_wdata};
            nchk++;
            if (obs !== exp) begin
                nerr++;
                $display("FAIL full_stall c=%0d got g=%b wr=%b r0=%b r1=%b d=%h exp g=%b wr=%b r0=%b r1=%b d=%h",
                         c, obs[12:11], obs[10], obs[9], obs[8], obs[7:0],
                         exp[12:11], exp[10], exp[9], exp[8], exp[7:0]);
            end
            if (req0_ready) i0++;
            if (req1_ready) i1++;
            @(negedge clk);
        end
        fifo_full = 1'b0;
    endtask

    task automatic test_valid_drop();
        logic [12:0] obs, exp;
        logic [1:0]  eg;
        logic        ew;
        logic [7:0]  ed;
        int unsigned i0, i1;
        do_reset();
        i0 = 0;
        i1 = 0;
        for (int c = 0; c <= 8; c++) begin
            req0_valid = (c <= 1);
            req1_valid = (c <= 6);
            req0_data  = 8'h50 + 8'(i0);
            req1_data  = 8'h60 + 8'(i1);
            #1;
            case (c)
                0:          begin eg = 2'b00; ew = 1'b0; ed = 8'h00; end
                1:          begin eg = 2'b01; ew = 1'b1; ed = 8'h50; end
                2:          begin eg = 2'b01; ew = 1'b0; ed = 8'h50; end
                3, 4, 5, 6: begin eg = 2'b10; ew = 1'b1; ed = 8'h60 + 8'(c - 3); end
                7:          begin eg = 2'b10; ew = 1'b0; ed = 8'h63; end
                default:    begin eg = 2'b00; ew = 1'b0; ed = 8'h63; end
            endcase
            exp = {eg, ew, ew & eg[0], ew & eg[1], ed};
            obs = {grant, fifo_wr, req0_ready, req1_ready, fifo_wdata};
            nchk++;
            if (obs !== exp) begin
                nerr++;
                $display("FAIL valid_drop c=%0d got g=%b wr=%b r0=%b r1=%b d=%h exp g=%b wr=%b r0=%b r1=%b d=%h",
                         c, obs[12:11], obs[10], obs[9], obs[8], obs[7:0],
                         exp[12:11], exp[10], exp[9], exp[8], exp[7:0]);
            end
            if (req0_ready) i0++;
            if (req1_ready) i1++;
            @(negedge clk);
        end
    endtask

    // Producer 1 holds the bus at cnt=2 when reset hits, so last_owner is 0
    // beforehand; the post-reset tie must still go to producer 0.
    task automatic test_reset_mid_burst();
        logic [12:0] obs, exp;
        logic [1:0]  eg;
        logic        ew;
        logic [7:0]  ed;
        int unsigned i0, i1;
        do_reset();
        i0 = 0;
        i1 = 0;
        for (int c = 0; c <= 13; c++) begin
            reset      = (c == 7);
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            req0_data  = 8'h70 + 8'(i0);
            req1_data  = 8'h80 + 8'(i1);
            #1;
            case (c)
                0:           begin eg = 2'b00; ew = 1'b0; ed = 8'h00; end
                1, 2, 3, 4:  begin eg = 2'b01; ew = 1'b1; ed = 8'h70 + 8'(c - 1); end
                5, 6:        begin eg = 2'b10; ew = 1'b1; ed = 8'h80 + 8'(c - 5); end
                7, 8:        begin eg = 2'b00; ew = 1'b0; ed = 8'h00; end
                9, 10,
                11, 12:      begin eg = 2'b01; ew = 1'b1; ed = 8'h74 + 8'(c - 9); end
                default:     begin eg = 2'b10; ew = 1'b1; ed = 8'h82; end
            endcase
            exp = {eg, ew, ew & eg[0], ew & eg[1], ed};
            obs = {grant, fifo_wr, req0_ready, req1_ready, fifo_wdata};
            nchk++;
            if (obs !== exp) begin
                nerr++;
                $display("FAIL reset_mid c=%0d got g=%b wr=%b r0=%b r1=%b d=%h exp g=%b wr=%b r0=%b r1=%b d=%h",
                         c, obs[12:11], obs[10], obs[9], obs[8], obs[7:0],
                         exp[12:11], exp[10], exp[9], exp[8], exp[7:0]);
            end
            if (req0_ready) i0++;
            if (req1_ready) i1++;
            @(negedge clk);
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream0();
        test_alternate();
        test_full_stall();
        test_valid_drop();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
